toilet_assay_sequencer: RTL and testbench

Cycle-accurate sequencer for the smart-toilet microfluidic assay: drives the three inlet pump valves (soln1, soln2, soln3) and the waste/flush valve feeding the serpentine-delay and diffusion-mixer network, then hands the mixed output to the downstream sensor. soln3 is dosed first because its path has the longest serpentine residency. soln2 and soln1 follow so that both streams meet at the mixers together. The block sits between the host configuration interface and the chip-level valve drivers.

---
 rtl/toilet_seq_pkg.sv | 10 +
 rtl/seq_down_timer.sv | 19 +
 rtl/toilet_assay_sequencer.sv | 89 ++++++++
 tb/tb_toilet_assay_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toilet_seq_pkg.sv
// toilet_seq_pkg: shared state encoding, default timer width and pump bit positions
package toilet_seq_pkg;
  localparam int DEF_TIMER_W = 16;
  localparam int PUMP_SOLN1 = 0;
  localparam int PUMP_SOLN2 = 1;
  localparam int PUMP_SOLN3 = 2;
  typedef enum logic [3:0] {
    IDLE, PRIME, DOSE3, DOSE2, DOSE1, INCUBATE, READOUT, DONE, ABORT_FLUSH
  } state_t;
endpackage

// File: rtl/seq_down_timer.sv
// seq_down_timer: loadable down-counter; expire flags the last cycle of a loaded duration
module seq_down_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - W'(1);
  // a zero load expires at once, so zero-length states still last one cycle
  assign expire = count <= W'(1);
endmodule

// File: rtl/toilet_assay_sequencer.sv
// toilet_assay_sequencer: valve/pump sequencer for the microfluidic assay with abort and readout timeout
module toilet_assay_sequencer
  import toilet_seq_pkg::*;
#(
  parameter int TIMER_W = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [TIMER_W-1:0] cfg_prime,
  input  logic [TIMER_W-1:0] cfg_dose3,
  input  logic [TIMER_W-1:0] cfg_dose2,
  input  logic [TIMER_W-1:0] cfg_dose1,
  input  logic [TIMER_W-1:0] cfg_incubate,
  input  logic [TIMER_W-1:0] cfg_flush,
  input  logic [TIMER_W-1:0] cfg_timeout,
  input  logic               sensor_ready,
  output logic [2:0]         pump_en,
  output logic               flush_valve,
  output logic               sample_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);
  typedef struct packed {
    logic [TIMER_W-1:0] prime, dose3, dose2, dose1, incubate, flush, timeout;
  } cfg_t;
  cfg_t cfg_q, cfg;
  state_t state, next;
  logic accept, hit, expire, load;
  logic [TIMER_W-1:0] dur;
  logic [2:0] pump_d;
  logic flush_d, sv_d, done_d, busy_d, err_d;
  // the accepted start uses the live config so PRIME can time from the very first cycle
  assign accept = state == IDLE && start;
  assign cfg = accept ? cfg_t'({cfg_prime, cfg_dose3, cfg_dose2, cfg_dose1, cfg_incubate, cfg_flush, cfg_timeout}) : cfg_q;
  assign hit = abort && state != IDLE && state != ABORT_FLUSH;
  assign load = next != state;
  assign dur = next == PRIME ? cfg.prime : next == DOSE3 ? cfg.dose3 : next == DOSE2 ? cfg.dose2 :
               next == DOSE1 ? cfg.dose1 : next == INCUBATE ? cfg.incubate :
               next == READOUT ? cfg.timeout : next == ABORT_FLUSH ? cfg.flush : '0;
  seq_down_timer #(.W(TIMER_W)) u_timer (
    .clk(clk), .rst(rst), .load(load), .en(1'b1), .load_val(dur), .expire(expire)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cfg_q <= '0;
      pump_en <= '0;
      flush_valve <= 1'b0;
      sample_valid <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= next;
      cfg_q <= cfg;
      pump_en <= pump_d;
      flush_valve <= flush_d;
      sample_valid <= sv_d;
      done <= done_d;
      busy <= busy_d;
      err <= err_d;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? PRIME : IDLE;
      PRIME, DOSE3, DOSE2, DOSE1, INCUBATE: next = expire ? state_t'(state + 4'd1) : state;
      READOUT: next = sample_valid && sensor_ready ? DONE : expire && cfg.timeout != '0 ? ABORT_FLUSH : READOUT;
      DONE: next = IDLE;
      default: next = expire ? IDLE : ABORT_FLUSH;
    endcase
    if (hit) next = ABORT_FLUSH;
  end
  // outputs are decoded from the upcoming state so they register alongside it
  always_comb begin
    pump_d = '0;
    pump_d[PUMP_SOLN3] = next == DOSE3 && dur != '0;
    pump_d[PUMP_SOLN2] = next == DOSE2 && dur != '0;
    pump_d[PUMP_SOLN1] = next == DOSE1 && dur != '0;
    flush_d = (next == PRIME || next == ABORT_FLUSH) && dur != '0;
    sv_d = next == READOUT;
    done_d = next == DONE;
    busy_d = next != IDLE;
    err_d = accept ? 1'b0 : (next == ABORT_FLUSH && state != ABORT_FLUSH) || err;
  end
endmodule

// File: tb/tb_toilet_assay_sequencer.sv
// tb_toilet_assay_sequencer: directed runs checked against a per-cycle timeline model
module tb_toilet_assay_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0, sensor_ready = 0;
  logic [15:0] cfg_prime, cfg_dose3, cfg_dose2, cfg_dose1, cfg_incubate, cfg_flush, cfg_timeout;
  logic [2:0] pump_en;
  logic flush_valve, sample_valid, busy, done, err;
  int n_chk = 0, n_fail = 0, cyc = 0, t_start = 0, t_done = 0;
  int c_p3 = 0, c_p2 = 0, c_p1 = 0, c_fl = 0, c_sv = 0, c_dn = 0;
  toilet_assay_sequencer #(.TIMER_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_prime(cfg_prime), .cfg_dose3(cfg_dose3), .cfg_dose2(cfg_dose2), .cfg_dose1(cfg_dose1),
    .cfg_incubate(cfg_incubate), .cfg_flush(cfg_flush), .cfg_timeout(cfg_timeout),
    .sensor_ready(sensor_ready), .pump_en(pump_en), .flush_valve(flush_valve),
    .sample_valid(sample_valid), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  // model: a queue of expected output cycles; the head is the current cycle
  typedef struct packed {logic [2:0] pump; logic flush, sv, dn, rd, fl;} ent_t;
  ent_t q[$];
  logic err_m = 0;
  int rc = 0, m_to = 0, m_fl = 0;
  task automatic seg(input int n, input logic [2:0] p, input logic f, input logic fl);
    ent_t e;
    e = '0;
    e.fl = fl;
    if (n != 0) begin
      e.pump = p;
      e.flush = f;
    end
    repeat (n == 0 ? 1 : n) q.push_back(e);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      err_m = 0;
    end else if (q.size() == 0) begin
      if (start) begin
        err_m = 0;
        rc = 0;
        m_to = int'(cfg_timeout);
        m_fl = int'(cfg_flush);
        seg(int'(cfg_prime), 3'b000, 1'b1, 1'b0);
        seg(int'(cfg_dose3), 3'b100, 1'b0, 1'b0);
        seg(int'(cfg_dose2), 3'b010, 1'b0, 1'b0);
        seg(int'(cfg_dose1), 3'b001, 1'b0, 1'b0);
        seg(int'(cfg_incubate), 3'b000, 1'b0, 1'b0);
        q.push_back(ent_t'({3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}));
      end
    end else if (abort && !q[0].fl) begin
      err_m = 1;
      q.delete();
      seg(m_fl, 3'b000, 1'b1, 1'b1);
    end else if (q[0].rd) begin
      if (sensor_ready) begin
        q.delete();
        q.push_back(ent_t'({3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
      end else begin
        rc++;
        if (m_to != 0 && rc == m_to) begin
          err_m = 1;
          q.delete();
          seg(m_fl, 3'b000, 1'b1, 1'b1);
        end
      end
    end else void'(q.pop_front());
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin : cmp
    ent_t e;
    cyc++;
    e = q.size() != 0 ? q[0] : '0;
    chk("pump_en", 32'(pump_en), 32'(e.pump));
    chk("flush_valve", 32'(flush_valve), 32'(e.flush));
    chk("sample_valid", 32'(sample_valid), 32'(e.sv));
    chk("done", 32'(done), 32'(e.dn));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("err", 32'(err), 32'(err_m));
    chk("valve_invariant", 32'($countones(pump_en) > 1 || (|pump_en && flush_valve)), 32'(0));
    if (start && q.size() == 0 && !rst) t_start = cyc;
    if (pump_en == 3'b100) c_p3++;
    if (pump_en == 3'b010) c_p2++;
    if (pump_en == 3'b001) c_p1++;
    if (flush_valve) c_fl++;
    if (sample_valid) c_sv++;
    if (done) begin
      c_dn++;
      t_done = cyc;
    end
  end
  task automatic setcfg(input int p, d3, d2, d1, i, f, t);
    cfg_prime = 16'(p); cfg_dose3 = 16'(d3); cfg_dose2 = 16'(d2); cfg_dose1 = 16'(d1);
    cfg_incubate = 16'(i); cfg_flush = 16'(f); cfg_timeout = 16'(t);
  endtask
  task automatic go();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_neg(input int what, input string nm);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = what == 0 ? sample_valid : what == 1 ? pump_en == 3'b010 : what == 2 ? pump_en == 3'b001 : pump_en == 3'b000;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL wait_%s: condition not reached within 300 cycles", nm);
    end
  endtask
  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #2;
      ok = !busy;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL idle_%s: busy still high after 300 cycles", nm);
    end
  endtask
  task automatic readout_hs(input int k);
    wait_neg(0, "readout");
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    sensor_ready = 1;
    @(posedge clk); #1;
    sensor_ready = 0;
  endtask
  initial begin : stim
    int s3, s2, s1, sf, ss, sd;
    setcfg(2, 3, 4, 5, 6, 3, 10);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_outputs", 32'({pump_en, flush_valve, sample_valid, done, busy, err}), 32'(0));
    // nominal run, handshake on the third readout cycle
    s3 = c_p3; s2 = c_p2; s1 = c_p1; sd = c_dn;
    go();
    readout_hs(3);
    wait_idle("nominal");
    chk("nom_latency", 32'(t_done - t_start), 32'(24));
    chk("nom_dose3_cycles", 32'(c_p3 - s3), 32'(3));
    chk("nom_dose2_cycles", 32'(c_p2 - s2), 32'(4));
    chk("nom_dose1_cycles", 32'(c_p1 - s1), 32'(5));
    chk("nom_done_pulses", 32'(c_dn - sd), 32'(1));
    chk("nom_err", 32'(err), 32'(0));
    // zero-length DOSE2
    setcfg(1, 1, 0, 1, 1, 3, 10);
    s3 = c_p3; s2 = c_p2; s1 = c_p1; sd = c_dn;
    sensor_ready = 1;
    go();
    wait_idle("zero");
    sensor_ready = 0;
    chk("zero_latency", 32'(t_done - t_start), 32'(7));
    chk("zero_dose2_cycles", 32'(c_p2 - s2), 32'(0));
    chk("zero_dose3_cycles", 32'(c_p3 - s3), 32'(1));
    chk("zero_dose1_cycles", 32'(c_p1 - s1), 32'(1));
    chk("zero_done_pulses", 32'(c_dn - sd), 32'(1));
    // abort during DOSE2
    setcfg(2, 3, 4, 5, 6, 4, 10);
    go();
    wait_neg(1, "dose2");
    sf = c_fl; sd = c_dn;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    wait_idle("abort");
    chk("abort_flush_cycles", 32'(c_fl - sf), 32'(4));
    chk("abort_err", 32'(err), 32'(1));
    chk("abort_done_pulses", 32'(c_dn - sd), 32'(0));
    // readout timeout, then a fresh start clears err
    setcfg(1, 1, 1, 1, 1, 2, 5);
    ss = c_sv; sd = c_dn; sf = c_fl;
    go();
    wait_idle("timeout");
    chk("timeout_sv_cycles", 32'(c_sv - ss), 32'(5));
    chk("timeout_flush_cycles", 32'(c_fl - sf), 32'(3));
    chk("timeout_err", 32'(err), 32'(1));
    chk("timeout_done_pulses", 32'(c_dn - sd), 32'(0));
    sensor_ready = 1;
    sd = c_dn;
    go();
    chk("restart_clears_err", 32'(err), 32'(0));
    wait_idle("restart");
    chk("restart_done_pulses", 32'(c_dn - sd), 32'(1));
    // start while busy is ignored
    sd = c_dn;
    go();
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_idle("busy_start");
    sensor_ready = 0;
    chk("busy_start_latency", 32'(t_done - t_start), 32'(7));
    chk("busy_start_done_pulses", 32'(c_dn - sd), 32'(1));
    // abort and handshake together in READOUT: abort wins
    setcfg(1, 1, 1, 1, 1, 2, 0);
    go();
    wait_neg(0, "collide");
    sd = c_dn;
    abort = 1;
    sensor_ready = 1;
    @(posedge clk); #1;
    abort = 0;
    sensor_ready = 0;
    wait_idle("collide");
    chk("collide_done_pulses", 32'(c_dn - sd), 32'(0));
    chk("collide_err", 32'(err), 32'(1));
    // start and abort together in IDLE: run starts
    sensor_ready = 1;
    abort = 1;
    sd = c_dn;
    go();
    abort = 0;
    chk("start_abort_busy", 32'(busy), 32'(1));
    chk("start_abort_err", 32'(err), 32'(0));
    wait_idle("start_abort");
    sensor_ready = 0;
    chk("start_abort_done_pulses", 32'(c_dn - sd), 32'(1));
    // reset during INCUBATE, then a full nominal run
    setcfg(2, 3, 4, 5, 6, 3, 10);
    go();
    wait_neg(2, "dose1");
    wait_neg(3, "incubate");
    rst = 1;
    @(posedge clk); #1;
    chk("midreset_outputs", 32'({pump_en, flush_valve, sample_valid, done, busy}), 32'(0));
    rst = 0;
    s3 = c_p3; sd = c_dn;
    go();
    readout_hs(3);
    wait_idle("after_reset");
    chk("rerun_latency", 32'(t_done - t_start), 32'(24));
    chk("rerun_dose3_cycles", 32'(c_p3 - s3), 32'(3));
    chk("rerun_done_pulses", 32'(c_dn - sd), 32'(1));
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
